// File: rtl/nbcac_21di_decoder_seq.sv
// NBCAC 21-bit receive decoder: digit-serial weighted sum of a 30-bit codeword,
// DPC digits per cycle, valid/ready handshake on both sides.
module nbcac_21di_decoder_seq #(
    parameter int DPC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [29:0] in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [20:0] out_data,
    output logic        out_err,
    output logic        busy
);

    localparam int N  = 30 / DPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Entry k holds weight s[k+1]; listed from s30 down to s1.
    localparam logic [29:0][20:0] WTAB = {
        21'd2,      21'd2,      21'd4,      21'd6,      21'd10,
        21'd16,     21'd26,     21'd42,     21'd68,     21'd110,
        21'd178,    21'd288,    21'd466,    21'd754,    21'd1220,
        21'd1974,   21'd3194,   21'd5168,   21'd8362,   21'd13530,
        21'd21892,  21'd35422,  21'd57314,  21'd92736,  21'd150050,
        21'd242786, 21'd392836, 21'd635622, 21'd1028458, 21'd1
    };

    logic [1:0]    state_q, state_d;
    logic [29:0]   shreg_q, shreg_d;
    logic [21:0]   acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [20:0]   data_q, data_d;
    logic          err_q, err_d;

    logic [21:0]   part;
    logic [21:0]   acc_sum;
    logic          accept;

    function automatic logic [20:0] weight(input int idx);
        logic [4:0] i5;
        i5 = 5'(idx);
        if (idx >= 0 && idx < 30) return WTAB[i5];
        return 21'd0;
    endfunction

    // Digits of this cycle occupy shreg_q[DPC-1:0]; their weights follow cnt.
    always_comb begin
        part = 22'd0;
        for (int j = 0; j < DPC; j++) begin
            if (shreg_q[j]) part = part + {1'b0, weight(int'(cnt_q) * DPC + j)};
        end
    end

    assign acc_sum  = acc_q + part;
    assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: ;
            S_RUN: begin
                acc_d   = acc_sum;
                shreg_d = shreg_q >> DPC;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    err_d   = (acc_sum > 22'd2097151);
                    data_d  = (acc_sum > 22'd2097151) ? 21'h0 : acc_sum[20:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A new word may arrive in IDLE or on the DONE handshake cycle.
        if (accept) begin
            shreg_d = in_code;
            acc_d   = 22'd0;
            cnt_d   = '0;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= 30'd0;
            acc_q   <= 22'd0;
            cnt_q   <= '0;
            data_q  <= 21'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign out_data  = data_q;
    assign out_err   = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_nbcac_21di_decoder_seq.sv
// Bench for nbcac_21di_decoder_seq: three instances (DPC=1,5,30) fed by a greedy
// NBCAC encoder model, checked through an expected-result queue.
module tb_nbcac_21di_decoder_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid  [3];
    logic        out_ready [3];
    logic [29:0] in_code   [3];
    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic        out_err_w   [3];
    logic        busy_w      [3];
    logic [20:0] out_data_w  [3];

    int NS [3] = '{30, 6, 1};
    int S [1:30] = '{1, 1028458, 635622, 392836, 242786, 150050, 92736, 57314, 35422, 21892,
                     13530, 8362, 5168, 3194, 1974, 1220, 754, 466, 288, 178,
                     110, 68, 42, 26, 16, 10, 6, 4, 2, 2};

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : u_dut
        localparam int D = (g == 0) ? 1 : (g == 1) ? 5 : 30;
        nbcac_21di_decoder_seq #(.DPC(D)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready_w[g]),
            .in_code  (in_code[g]),
            .out_valid(out_valid_w[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data_w[g]),
            .out_err  (out_err_w[g]),
            .busy     (busy_w[g])
        );
    end

    // Greedy encoder over the descending weights s2..s30, s1 absorbs the remainder.
    function automatic logic [29:0] enc(input int v);
        logic [29:0] c;
        int r;
        c = 30'd0;
        r = v;
        for (int k = 2; k <= 30; k++) begin
            if (r >= S[k]) begin
                c[k-1] = 1'b1;
                r = r - S[k];
            end
        end
        if (r == 1) c[0] = 1'b1;
        return c;
    endfunction

    task automatic test_reset();
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (out_valid_w[u] !== 1'b0 || busy_w[u] !== 1'b0 || out_data_w[u] !== 21'd0 ||
                out_err_w[u] !== 1'b0 || in_ready_w[u] !== 1'b1) begin
                errors++;
                $display("FAIL reset u%0d: valid=%b busy=%b data=%0d err=%b rdy=%b, need 0 0 0 0 1",
                         u, out_valid_w[u], busy_w[u], out_data_w[u], out_err_w[u], in_ready_w[u]);
            end
        end
    endtask

    // One word through unit u with out_ready held high; checks latency, value, release.
    task automatic run_word(input int u, input logic [29:0] code, input logic [20:0] ed,
                            input logic ee, input string name);
        int t;
        int lat;
        @(negedge clk);
        in_code[u]   = code;
        in_valid[u]  = 1'b1;
        out_ready[u] = 1'b1;
        #1;
        t = 0;
        while (!in_ready_w[u] && t < 100) begin
            @(negedge clk); #1; t++;
        end
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        lat = 0;
        while (!out_valid_w[u] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== NS[u]) begin
            errors++;
            $display("FAIL %s latency u%0d: got %0d cycles, need %0d", name, u, lat, NS[u]);
        end
        checks++;
        if (out_data_w[u] !== ed || out_err_w[u] !== ee) begin
            errors++;
            $display("FAIL %s data u%0d: got %0d err=%b, need %0d err=%b",
                     name, u, out_data_w[u], out_err_w[u], ed, ee);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid_w[u] !== 1'b0 || busy_w[u] !== 1'b0) begin
            errors++;
            $display("FAIL %s release u%0d: valid=%b busy=%b, need 0 0", name, u,
                     out_valid_w[u], busy_w[u]);
        end
    endtask

    task automatic test_directed();
        run_word(0, 30'h0000_0000, 21'd0, 1'b0, "zero");
        run_word(0, 30'h0000_0001, 21'd1, 1'b0, "d1");
        run_word(0, 30'h2000_0000, 21'd2, 1'b0, "d30");
        run_word(0, 30'h0000_000C, 21'd1028458, 1'b0, "d3d4");
        run_word(1, 30'h0000_000C, 21'd1028458, 1'b0, "d3d4");
        run_word(2, 30'h2000_0001, 21'd3, 1'b0, "d1d30");
        run_word(0, enc(2097151), 21'd2097151, 1'b0, "max");
        run_word(1, enc(2097152), 21'd0, 1'b1, "max+1");
    endtask

    task automatic test_overflow();
        for (int u = 0; u < 3; u++) run_word(u, 30'h3FFF_FFFF, 21'd0, 1'b1, "allones");
    endtask

    task automatic test_stall_back_to_back();
        int t;
        int lat;
        @(negedge clk);
        in_code[0] = enc(123456);
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        t = 0;
        while (!out_valid_w[0] && t < 100) begin
            @(posedge clk); #1; t++;
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid_w[0] !== 1'b1 || out_data_w[0] !== 21'd123456 || in_ready_w[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall cyc%0d: valid=%b data=%0d rdy=%b, need 1 123456 0",
                         i, out_valid_w[0], out_data_w[0], in_ready_w[0]);
            end
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_code[0]   = enc(654321);
        #1;
        checks++;
        if (in_ready_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b in_ready: got %b, need 1", in_ready_w[0]);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        checks++;
        if (busy_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b restart: busy=%b valid=%b, need 1 0", busy_w[0], out_valid_w[0]);
        end
        lat = 0;
        while (!out_valid_w[0] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 30 || out_data_w[0] !== 21'd654321 || out_err_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b second: lat=%0d data=%0d err=%b, need 30 654321 0",
                     lat, out_data_w[0], out_err_w[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        in_code[0] = enc(777777);
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_w[0] !== 1'b0 || out_valid_w[0] !== 1'b0 || out_data_w[0] !== 21'd0 ||
            out_err_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrun reset: busy=%b valid=%b data=%0d err=%b rdy=%b, need 0 0 0 0 1",
                     busy_w[0], out_valid_w[0], out_data_w[0], out_err_w[0], in_ready_w[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_word(0, enc(4242), 21'd4242, 1'b0, "after_reset");
    endtask

    task automatic test_random(input int u, input int nwords);
        logic [21:0] q[$];
        logic [21:0] e;
        int sent;
        int cyc;
        int v;
        logic acc;
        sent = 0;
        cyc  = 0;
        v    = 0;
        in_valid[u] = 1'b0;
        while ((sent < nwords || q.size() > 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (!in_valid[u] && sent < nwords && $urandom_range(3) != 0) begin
                v = int'($urandom_range(2097151));
                in_code[u]  = enc(v);
                in_valid[u] = 1'b1;
            end
            out_ready[u] = ($urandom_range(3) != 0);
            #1;
            if (out_valid_w[u] && out_ready[u]) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL random u%0d: unexpected output %0d", u, out_data_w[u]);
                end else begin
                    e = q.pop_front();
                    if ({out_err_w[u], out_data_w[u]} !== e) begin
                        errors++;
                        $display("FAIL random u%0d: got %0d err=%b, need %0d err=%b",
                                 u, out_data_w[u], out_err_w[u], e[20:0], e[21]);
                    end
                end
            end
            acc = in_valid[u] & in_ready_w[u];
            if (acc) begin
                q.push_back({1'b0, 21'(v)});
                sent++;
            end
            @(posedge clk); #1;
            if (acc) in_valid[u] = 1'b0;
        end
        checks++;
        if (cyc >= 40000) begin
            errors++;
            $display("FAIL random u%0d timeout: sent %0d, pending %0d", u, sent, q.size());
        end
        out_ready[u] = 1'b1;
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            in_valid[u]  = 1'b0;
            out_ready[u] = 1'b0;
            in_code[u]   = 30'd0;
        end
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed();
        test_overflow();
        test_stall_back_to_back();
        test_reset_mid_run();
        test_random(0, 500);
        test_random(1, 2500);
        test_random(2, 1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
